// File: rtl/alu_sched.sv
`default_nettype none
// ============================================================================
// Module   : alu_sched
// Purpose  : Round-robin scheduler that shares one registered ALU among
//            NUM_REQ requesters. It takes one operation at a time, drives
//            the ALU operand/opcode ports, captures the ALU's registered
//            result and returns it on a single response channel tagged with
//            the requester index. Illegal opcodes (101..111) bypass the ALU
//            and produce result=0, error=1.
// Ports    : clk, rst                 clock / synchronous active-high reset
//            req_valid/req_ready      per-requester handshake (one-hot grant)
//            req_a/req_b/req_opcode   packed per-requester operation fields
//            alu_a/alu_b/alu_opcode   operation driven to the ALU
//            alu_result/alu_error     registered ALU outputs
//            rsp_valid/rsp_ready      response handshake
//            rsp_id/rsp_result/rsp_error  response payload
// Revision : 1.0 - initial release
// ============================================================================
module alu_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  input  logic [3*NUM_REQ-1:0]  req_opcode,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  output logic [2:0]            alu_opcode,
  input  logic [31:0]           alu_result,
  input  logic                  alu_error,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_result,
  output logic                  rsp_error
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  // Distances are one bit wider than the id so NUM_REQ itself can serve as
  // the "no candidate yet" sentinel at the head of the selection chain.
  localparam logic [ID_W:0]   C_NUM     = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] C_LAST    = ID_W'(NUM_REQ-1);
  localparam logic [2:0]      C_MAX_OP  = 3'd4;

  state_t          r_state;
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] r_id;
  logic [31:0]     r_a;
  logic [31:0]     r_b;
  logic [2:0]      r_op;
  logic [31:0]     r_result;
  logic            r_error;
  logic            r_rsp_valid;

  // Selection chain: stage i+1 holds the best valid requester among 0..i,
  // where "best" means smallest wrapped distance above the round-robin pointer.
  logic [ID_W:0]   w_chain_dist [NUM_REQ+1];
  logic [ID_W-1:0] w_chain_id   [NUM_REQ+1];
  logic [31:0]     w_chain_a    [NUM_REQ+1];
  logic [31:0]     w_chain_b    [NUM_REQ+1];
  logic [2:0]      w_chain_op   [NUM_REQ+1];

  logic            w_any;
  logic            w_grant;
  logic [ID_W-1:0] w_gnt_id;
  logic [31:0]     w_gnt_a;
  logic [31:0]     w_gnt_b;
  logic [2:0]      w_gnt_op;

  assign w_chain_dist[0] = C_NUM;
  assign w_chain_id[0]   = '0;
  assign w_chain_a[0]    = '0;
  assign w_chain_b[0]    = '0;
  assign w_chain_op[0]   = '0;

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
      localparam logic [ID_W:0] C_IDX = (ID_W+1)'(i);
      logic [ID_W:0] w_dist;
      logic          w_take;

      // (i - rr_ptr) mod NUM_REQ without a divider.
      assign w_dist = (C_IDX >= {1'b0, r_rr_ptr}) ? (C_IDX - {1'b0, r_rr_ptr})
                                                 : (C_IDX + C_NUM - {1'b0, r_rr_ptr});
      assign w_take = req_valid[i] && (w_dist < w_chain_dist[i]);

      assign w_chain_dist[i+1] = w_take ? w_dist               : w_chain_dist[i];
      assign w_chain_id[i+1]   = w_take ? C_IDX[ID_W-1:0]      : w_chain_id[i];
      assign w_chain_a[i+1]    = w_take ? req_a[32*i +: 32]    : w_chain_a[i];
      assign w_chain_b[i+1]    = w_take ? req_b[32*i +: 32]    : w_chain_b[i];
      assign w_chain_op[i+1]   = w_take ? req_opcode[3*i +: 3] : w_chain_op[i];
    end
  endgenerate

  assign w_any    = (w_chain_dist[NUM_REQ] != C_NUM);
  assign w_gnt_id = w_chain_id[NUM_REQ];
  assign w_gnt_a  = w_chain_a[NUM_REQ];
  assign w_gnt_b  = w_chain_b[NUM_REQ];
  assign w_gnt_op = w_chain_op[NUM_REQ];

  // Grant is combinational and only ever offered from IDLE.
  assign w_grant   = (r_state == S_IDLE) && w_any;
  assign req_ready = w_grant ? (NUM_REQ'(1) << w_gnt_id) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_result    <= '0;
      r_error     <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_a      <= w_gnt_a;
            r_b      <= w_gnt_b;
            r_op     <= w_gnt_op;
            r_id     <= w_gnt_id;
            r_rr_ptr <= (w_gnt_id == C_LAST) ? '0 : (w_gnt_id + ID_W'(1));
            if (w_gnt_op > C_MAX_OP) begin
              // Illegal opcode: answer immediately without using the ALU.
              r_result    <= '0;
              r_error     <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_result    <= alu_result;
          r_error     <= alu_error;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  // ALU ports follow the operand registers in every state.
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_opcode = r_op;

  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_id;
  assign rsp_result = r_result;
  assign rsp_error  = r_error;

endmodule
`default_nettype wire

// File: tb/tb_alu_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sched
// Purpose  : Directed self-checking bench for alu_sched with a behavioural
//            registered ALU (000 add, 001 sub, 010 and, 011 or, 100 xor;
//            error = carry out on add, borrow on sub).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sched;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [3*NUM_REQ-1:0]  req_opcode;
  logic [31:0]           alu_a;
  logic [31:0]           alu_b;
  logic [2:0]            alu_opcode;
  logic [31:0]           alu_result;
  logic                  alu_error;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_result;
  logic                  rsp_error;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp6 [3];
  logic [2:0]  op6  [3];

  alu_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_opcode (req_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .alu_error  (alu_error),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_error  (rsp_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural registered ALU sitting beside the scheduler.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result <= '0;
      alu_error  <= 1'b0;
    end else begin
      case (alu_opcode)
        3'd0: {alu_error, alu_result} <= {1'b0, alu_a} + {1'b0, alu_b};
        3'd1: begin
          alu_result <= alu_a - alu_b;
          alu_error  <= (alu_a < alu_b);
        end
        3'd2: begin alu_result <= alu_a & alu_b; alu_error <= 1'b0; end
        3'd3: begin alu_result <= alu_a | alu_b; alu_error <= 1'b0; end
        3'd4: begin alu_result <= alu_a ^ alu_b; alu_error <= 1'b0; end
        default: begin alu_result <= '0; alu_error <= 1'b1; end
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
    req_a[32*i +: 32]     = a;
    req_b[32*i +: 32]     = b;
    req_opcode[3*i +: 3]  = op;
  endtask

  initial begin
    exp6[0] = 32'h00F000F0; op6[0] = 3'b010;
    exp6[1] = 32'hFFF0FFF0; op6[1] = 3'b011;
    exp6[2] = 32'hFF00FF00; op6[2] = 3'b100;

    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_opcode = '0;
    rsp_ready  = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    settle();

    // Reset values
    chk("rst_req_ready",  {28'b0, req_ready}, 32'h0);
    chk("rst_rsp_valid",  {31'b0, rsp_valid}, 32'h0);
    chk("rst_rsp_id",     {30'b0, rsp_id},    32'h0);
    chk("rst_rsp_result", rsp_result,         32'h0);
    chk("rst_rsp_error",  {31'b0, rsp_error}, 32'h0);
    chk("rst_alu_a",      alu_a,              32'h0);
    chk("rst_alu_b",      alu_b,              32'h0);
    chk("rst_alu_opcode", {29'b0, alu_opcode}, 32'h0);

    // 1: single legal op from requester 2
    set_req(2, 32'd5, 32'd3, 3'b000);
    req_valid = 4'b0100;
    settle();
    chk("t1_grant", {28'b0, req_ready}, 32'h4);
    tick();
    req_valid = '0;
    settle();
    chk("t1_issue_ready", {28'b0, req_ready}, 32'h0);
    chk("t1_issue_valid", {31'b0, rsp_valid}, 32'h0);
    chk("t1_alu_a",       alu_a,              32'd5);
    chk("t1_alu_b",       alu_b,              32'd3);
    chk("t1_alu_op",      {29'b0, alu_opcode}, 32'h0);
    tick();
    chk("t1_cap_valid",   {31'b0, rsp_valid}, 32'h0);
    tick();
    chk("t1_rsp_valid",   {31'b0, rsp_valid}, 32'h1);
    chk("t1_rsp_id",      {30'b0, rsp_id},    32'd2);
    chk("t1_rsp_result",  rsp_result,         32'd8);
    chk("t1_rsp_error",   {31'b0, rsp_error}, 32'h0);
    tick();
    chk("t1_idle_valid",  {31'b0, rsp_valid}, 32'h0);

    // 2: round-robin with all requesters valid from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'd100 + 32'(i), 32'(i), 3'b000);
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      int g;
      g = n % 4;
      settle();
      chk("t2_grant",      {28'b0, req_ready}, 32'h1 << g);
      chk("t2_idle_valid", {31'b0, rsp_valid}, 32'h0);
      tick();
      chk("t2_issue_ready", {28'b0, req_ready}, 32'h0);
      tick();
      tick();
      chk("t2_rsp_valid",  {31'b0, rsp_valid}, 32'h1);
      chk("t2_rsp_id",     {30'b0, rsp_id},    32'(g));
      chk("t2_rsp_result", rsp_result,         32'd100 + 32'(2*g));
      tick();
    end
    req_valid = '0;

    // 3: illegal opcode from requester 1 (pointer now at 1)
    set_req(1, 32'd7, 32'd7, 3'b110);
    req_valid = 4'b0010;
    settle();
    chk("t3_grant", {28'b0, req_ready}, 32'h2);
    tick();
    req_valid = '0;
    settle();
    chk("t3_rsp_valid",  {31'b0, rsp_valid}, 32'h1);
    chk("t3_rsp_id",     {30'b0, rsp_id},    32'd1);
    chk("t3_rsp_result", rsp_result,         32'h0);
    chk("t3_rsp_error",  {31'b0, rsp_error}, 32'h1);
    tick();
    chk("t3_idle_valid", {31'b0, rsp_valid}, 32'h0);

    // 4: back-pressure with requesters 0 and 3 valid (pointer at 2 -> 3 first)
    rsp_ready = 1'b0;
    set_req(0, 32'd9,   32'd4,  3'b001);
    set_req(3, 32'd100, 32'd23, 3'b000);
    req_valid = 4'b1001;
    settle();
    chk("t4_grant3", {28'b0, req_ready}, 32'h8);
    tick();
    req_valid = 4'b0001;
    tick();
    tick();
    for (int n = 0; n < 10; n++) begin
      chk("t4_hold_valid",  {31'b0, rsp_valid}, 32'h1);
      chk("t4_hold_id",     {30'b0, rsp_id},    32'd3);
      chk("t4_hold_result", rsp_result,         32'd123);
      chk("t4_hold_ready",  {28'b0, req_ready}, 32'h0);
      tick();
    end
    rsp_ready = 1'b1;
    settle();
    chk("t4_hs_ready", {28'b0, req_ready}, 32'h0);
    tick();
    chk("t4_grant0",      {28'b0, req_ready}, 32'h1);
    chk("t4_after_valid", {31'b0, rsp_valid}, 32'h0);
    tick();
    req_valid = '0;
    tick();
    tick();
    chk("t4_rsp_valid",  {31'b0, rsp_valid}, 32'h1);
    chk("t4_rsp_id",     {30'b0, rsp_id},    32'd0);
    chk("t4_rsp_result", rsp_result,         32'd5);
    chk("t4_rsp_error",  {31'b0, rsp_error}, 32'h0);
    tick();

    // 5: reset during CAPTURE drops the op and rewinds the pointer
    set_req(2, 32'hFFFFFFFF, 32'd1, 3'b001);
    req_valid = 4'b0100;
    settle();
    chk("t5_grant2", {28'b0, req_ready}, 32'h4);
    tick();
    req_valid = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_post_valid",  {31'b0, rsp_valid}, 32'h0);
    chk("t5_post_result", rsp_result,         32'h0);
    tick();
    chk("t5_no_rsp", {31'b0, rsp_valid}, 32'h0);
    set_req(1, 32'hA, 32'h3, 3'b100);
    set_req(3, 32'h5, 32'h5, 3'b000);
    req_valid = 4'b1010;
    settle();
    chk("t5_grant1", {28'b0, req_ready}, 32'h2);
    tick();
    req_valid = '0;
    tick();
    tick();
    chk("t5_rsp_valid",  {31'b0, rsp_valid}, 32'h1);
    chk("t5_rsp_id",     {30'b0, rsp_id},    32'd1);
    chk("t5_rsp_result", rsp_result,         32'h9);
    tick();

    // 6: logic ops from requester 3
    for (int n = 0; n < 3; n++) begin
      set_req(3, 32'hF0F0F0F0, 32'h0FF00FF0, op6[n]);
      req_valid = 4'b1000;
      settle();
      chk("t6_grant", {28'b0, req_ready}, 32'h8);
      tick();
      req_valid = '0;
      tick();
      tick();
      chk("t6_rsp_valid",  {31'b0, rsp_valid}, 32'h1);
      chk("t6_rsp_id",     {30'b0, rsp_id},    32'd3);
      chk("t6_rsp_result", rsp_result,         exp6[n]);
      chk("t6_rsp_error",  {31'b0, rsp_error}, 32'h0);
      tick();
      chk("t6_idle_valid", {31'b0, rsp_valid}, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_sched.md
# alu_sched

Round-robin scheduler that shares one `alu` instance among `NUM_REQ` independent requesters. Each requester presents an operation (A, B, Opcode) with a valid/ready handshake. The block grants one requester at a time and drives the ALU operand and opcode ports. It captures the ALU's registered Result/Error and returns them on a single response channel tagged with the requester index. Only one operation is in flight at a time; the ALU is instantiated beside this block and shares its clock and reset.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters (2..8).
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester tag.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester operation valid.
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- `req_a`  in  32*NUM_REQ  operand A; requester i occupies bits [32i+31:32i].
- `req_b`  in  32*NUM_REQ  operand B, same packing.
- `req_opcode`  in  3*NUM_REQ  opcode; requester i occupies bits [3i+2:3i].
- `alu_a`  out  32  to ALU A.
- `alu_b`  out  32  to ALU B.
- `alu_opcode`  out  3  to ALU Opcode.
- `alu_result`  in  32  from ALU Result (registered in ALU).
- `alu_error`  in  1  from ALU Error (registered in ALU).
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  ID_W  index of the requester that issued the operation.
- `rsp_result`  out  32  operation result.
- `rsp_error`  out  1  error flag for the operation.

## Operation
The FSM has four states: IDLE, ISSUE, CAPTURE, RESP. Reset state is IDLE.

- **IDLE**
  - If any `req_valid` bit is high, grant index g. g is the first set bit found by searching upward from `rr_ptr` and wrapping modulo NUM_REQ.
  - `req_ready[g]` is asserted combinationally in the same cycle. No other `req_ready` bit is asserted, and none are asserted in any other state.
  - On that edge: latch `req_a[g]`, `req_b[g]` and `req_opcode[g]` into the operand registers, set the id register to g, and set `rr_ptr` to (g+1) mod NUM_REQ.
  - If the latched opcode is 000..100, go to ISSUE.
  - If the opcode is 101..111 (illegal), the ALU is bypassed: load `rsp_result` = 0, load `rsp_error` = 1, and go directly to RESP.
- **ISSUE**
  - `alu_a`, `alu_b` and `alu_opcode` carry the latched operation. The ALU registers its output at the end of this cycle.
  - Go to CAPTURE unconditionally.
- **CAPTURE**
  - At the end of this cycle, load `rsp_result` from `alu_result` and `rsp_error` from `alu_error`.
  - Go to RESP.
- **RESP**
  - `rsp_valid` = 1. `rsp_id`, `rsp_result` and `rsp_error` are held stable while `rsp_valid` is high.
  - When `rsp_valid` and `rsp_ready` are both high at an edge, go to IDLE.
  - A new request is not accepted in the cycle the response completes; acceptance resumes the following cycle.
- **ALU drive:** `alu_a`, `alu_b` and `alu_opcode` always reflect the operand registers; they are not gated by state. Their values outside ISSUE are don't-care to the ALU's consumers and are never sampled.
- **Requester rules:** a requester must hold its valid and operands stable until it sees its `req_ready` bit. Deasserting valid before the grant is permitted and simply removes that requester from arbitration.
- **Arithmetic:** the block performs no arithmetic beyond the round-robin pointer increment.

## Timing
- Reset values:
  - `req_ready` = 0, `rsp_valid` = 0.
  - `rsp_id` = 0, `rsp_result` = 0, `rsp_error` = 0.
  - `alu_a` = 0, `alu_b` = 0, `alu_opcode` = 000.
  - `rr_ptr` = 0, state = IDLE.
- Legal opcode: accepted in cycle T, ISSUE in T+1, CAPTURE in T+2, `rsp_valid` first high in T+3.
- Illegal opcode: accepted in cycle T, `rsp_valid` first high in T+1.
- Throughput with `rsp_ready` tied high: one legal operation every 4 cycles, one illegal operation every 2 cycles.
- Reset asserted in any state: on the next edge the FSM returns to IDLE, `rsp_valid` = 0 and `rr_ptr` = 0. The in-flight operation is dropped with no response.
- Back-pressure: with `rsp_ready` low, the FSM holds in RESP indefinitely and all `req_ready` bits stay 0.
- Simultaneous requests: exactly one grant per IDLE cycle. Starvation is bounded: a continuously valid requester waits at most NUM_REQ-1 grants.

## Test plan
1. **Single legal op.** After reset, req 2 drives A=5, B=3, op=000. Expect `req_ready[2]` high in cycle T, then `rsp_valid` at T+3 with id=2, result=8.
2. **Round-robin order.** All 4 requesters valid continuously from reset. Expect grant order 0,1,2,3,0. Each `rsp_id` matches, and responses are 4 cycles apart with `rsp_ready`=1.
3. **Illegal opcode.** Req 1 drives op=110, A=7, B=7. Expect `rsp_valid` at T+1 with id=1, result=0, error=1, and no ISSUE state visited.
4. **Back-pressure.** Hold `rsp_ready`=0 for 10 cycles while req 0 and req 3 are valid. Expect `rsp_valid` held, outputs stable and `req_ready`=0 throughout. Raise `rsp_ready` and expect the next grant one cycle after the handshake.
5. **Reset mid-operation.** Assert `rst` for one cycle during CAPTURE of A=0xFFFFFFFF, B=1, op=001. Expect no response, state IDLE, and the next grant starting from req 0.
6. **Logic ops.** Req 3 drives A=0xF0F0F0F0, B=0x0FF00FF0 with ops 010, 011 and 100. Expect results 0x00F000F0, 0xFFF0FFF0 and 0xFF00FF00 respectively.
